// File: rtl/uart_pack_fifo_pkg.sv
// uart_pack_fifo_pkg
//   Shared defaults and helpers for the UART-to-SRAM packing FIFO.
//   IN_W_DEF / RATIO_DEF / DEPTH_DEF : default beat width, beats per word, word depth
//   cnt_width(n)                     : bits needed to hold the values 0..n
package uart_pack_fifo_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int RATIO_DEF = 2;
  localparam int DEPTH_DEF = 16;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_pack_stage.sv
// uart_pack_stage
//   Assembles RATIO input beats into one little-endian output word and hands
//   it to the storage when complete or when flushed (zero-padded).
//   Ports:
//     clk, rst_n       single clock, synchronous active-low reset
//     data_in          input beat
//     en_write         write strobe (ignored while full)
//     flush            push the partial word, if any
//     full             storage full, evaluated on pre-edge state
//     push             word is written into storage on this edge
//     push_word        word being pushed (valid with push)
//     pack_cnt         beats currently held in the packer
module uart_pack_stage
  import uart_pack_fifo_pkg::*;
#(
  parameter  int IN_W   = IN_W_DEF,
  parameter  int RATIO  = RATIO_DEF,
  localparam int OUT_W  = IN_W * RATIO,
  localparam int PACK_W = cnt_width(RATIO)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   data_in,
  input  logic              en_write,
  input  logic              flush,
  input  logic              full,
  output logic              push,
  output logic [OUT_W-1:0]  push_word,
  output logic [PACK_W-1:0] pack_cnt
);

  logic [OUT_W-1:0]  word_q, word_d;
  logic [PACK_W-1:0] pack_cnt_q, pack_cnt_d;
  logic [OUT_W-1:0]  asm_word;
  logic [PACK_W-1:0] beats;
  logic              accept;

  always_comb begin
    accept   = en_write && !full;
    asm_word = word_q;
    beats    = pack_cnt_q;
    if (accept) begin
      asm_word[int'(pack_cnt_q)*IN_W +: IN_W] = data_in;
      beats = pack_cnt_q + PACK_W'(1);
    end
    // The register is cleared after every push, so unwritten upper beats of a
    // flushed word are already zero. A beat written together with flush is
    // included in the single pushed word.
    push = !full && (beats != '0) && ((beats == PACK_W'(RATIO)) || flush);
    push_word = asm_word;
    if (push) begin
      word_d     = '0;
      pack_cnt_d = '0;
    end else begin
      word_d     = asm_word;
      pack_cnt_d = beats;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q     <= '0;
      pack_cnt_q <= '0;
    end else begin
      word_q     <= word_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  assign pack_cnt = pack_cnt_q;

endmodule

// File: rtl/uart_pack_fifo.sv
// uart_pack_fifo
//   Width-converting FIFO: packs RATIO beats of IN_W bits into OUT_W words
//   and stores up to DEPTH words for an SRAM write port.
//   Optional error flags are enabled by defining UART_PACK_FIFO_ERR_EN.
//   Ports:
//     clk, rst_n         single clock, synchronous active-low reset
//     data_in, en_write  input beat and its strobe
//     flush              push a partially packed word (zero-padded)
//     en_read            pop the oldest word into data_out (registered)
//     data_out           last popped word, holds between reads
//     empty, full        data_cnt == 0 / data_cnt == DEPTH
//     data_cnt           stored words, packer contents excluded
//     pack_cnt           beats held in the packer
//     ovf, udf           (ERR_EN only) sticky dropped-write / empty-read flags
module uart_pack_fifo
  import uart_pack_fifo_pkg::*;
#(
  parameter  int IN_W   = IN_W_DEF,
  parameter  int RATIO  = RATIO_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int OUT_W  = IN_W * RATIO,
  localparam int CNT_W  = cnt_width(DEPTH),
  localparam int PACK_W = cnt_width(RATIO)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   data_in,
  input  logic              en_write,
  input  logic              flush,
  input  logic              en_read,
  output logic [OUT_W-1:0]  data_out,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  data_cnt,
`ifdef UART_PACK_FIFO_ERR_EN
  output logic              ovf,
  output logic              udf,
`endif
  output logic [PACK_W-1:0] pack_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic             push, pop;
  logic [OUT_W-1:0] push_word;

  // Flags come straight from the registered count, so they cannot glitch.
  assign empty = (data_cnt_q == '0);
  assign full  = (data_cnt_q == CNT_W'(DEPTH));

  uart_pack_stage #(
    .IN_W  (IN_W),
    .RATIO (RATIO)
  ) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .en_write  (en_write),
    .flush     (flush),
    .full      (full),
    .push      (push),
    .push_word (push_word),
    .pack_cnt  (pack_cnt)
  );

  always_comb begin
    pop        = en_read && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_cnt_d = data_cnt_q;
    data_out_d = data_out_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = mem_q[rd_ptr_q];
    end
    // push is already blocked when full, so the count stays within 0..DEPTH.
    case ({push, pop})
      2'b10:   data_cnt_d = data_cnt_q + CNT_W'(1);
      2'b01:   data_cnt_d = data_cnt_q - CNT_W'(1);
      default: data_cnt_d = data_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_cnt_q <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_cnt_q <= data_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage needs no reset; only words behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= push_word;
  end

  assign data_out = data_out_q;
  assign data_cnt = data_cnt_q;

`ifdef UART_PACK_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (en_write && full);
    udf_d = udf_q | (en_read && empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_uart_pack_fifo.sv
// tb_uart_pack_fifo
//   Self-checking bench for uart_pack_fifo with default parameters
//   (8-bit beats, 2 beats per word, 16 words). A queue-based reference model
//   tracks stored words and packer state; a vector table covers packing and
//   flush, followed by hand-written fill/drain, simultaneous, reset and
//   random sequences.
module tb_uart_pack_fifo;

  localparam int IN_W  = 8;
  localparam int RATIO = 2;
  localparam int DEPTH = 16;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [IN_W-1:0]  data_in = '0;
  logic             en_write = 1'b0;
  logic             flush = 1'b0;
  logic             en_read = 1'b0;
  logic [OUT_W-1:0] data_out;
  logic             empty, full;
  logic [4:0]       data_cnt;
  logic [1:0]       pack_cnt;
`ifdef UART_PACK_FIFO_ERR_EN
  logic             ovf, udf;
`endif

  uart_pack_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .en_write (en_write),
    .flush    (flush),
    .en_read  (en_read),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .data_cnt (data_cnt),
`ifdef UART_PACK_FIFO_ERR_EN
    .ovf      (ovf),
    .udf      (udf),
`endif
    .pack_cnt (pack_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [OUT_W-1:0] sb_q[$];
  logic [OUT_W-1:0] m_buf;
  int               m_pack;
  logic [OUT_W-1:0] m_dout;
  bit               m_ovf, m_udf;

  typedef struct {
    bit               w;
    logic [IN_W-1:0]  d;
    bit               f;
    bit               r;
    int               cnt;
    int               pack;
    logic [OUT_W-1:0] dout;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_buf  = '0;
    m_pack = 0;
    m_dout = '0;
    m_ovf  = 0;
    m_udf  = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " data_out"}, 32'(data_out), 32'(m_dout));
    chk({tag, " data_cnt"}, 32'(data_cnt), 32'(sb_q.size()));
    chk({tag, " pack_cnt"}, 32'(pack_cnt), 32'(m_pack));
    chk({tag, " empty"}, 32'(empty), 32'(sb_q.size() == 0));
    chk({tag, " full"}, 32'(full), 32'(sb_q.size() == DEPTH));
`ifdef UART_PACK_FIFO_ERR_EN
    chk({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, " udf"}, 32'(udf), 32'(m_udf));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_write = 0; flush = 0; en_read = 0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_state("reset");
    rst_n = 1'b1;
  endtask

  task automatic step(input bit w, input logic [IN_W-1:0] d, input bit f, input bit r,
                      input string tag);
    bit m_full, m_empty;
    en_write = w; data_in = d; flush = f; en_read = r;
    @(posedge clk);
    #1;
    m_full  = (sb_q.size() == DEPTH);
    m_empty = (sb_q.size() == 0);
    if (w && m_full) m_ovf = 1;
    if (r && m_empty) m_udf = 1;
    if (r && !m_empty) m_dout = sb_q.pop_front();
    if (w && !m_full) begin
      m_buf[m_pack*IN_W +: IN_W] = d;
      m_pack++;
    end
    if (!m_full && m_pack > 0 && (m_pack == RATIO || f)) begin
      sb_q.push_back(m_buf);
      m_buf  = '0;
      m_pack = 0;
    end
    en_write = 0; flush = 0; en_read = 0;
    check_state(tag);
  endtask

  initial begin
    tbl = '{
      '{1, 8'h21, 0, 0, 0, 1, 16'h0000},
      '{1, 8'h45, 0, 0, 1, 0, 16'h0000},
      '{0, 8'h00, 0, 1, 0, 0, 16'h4521},
      '{1, 8'h76, 0, 0, 0, 1, 16'h4521},
      '{0, 8'h00, 1, 0, 1, 0, 16'h4521},
      '{0, 8'h00, 1, 0, 1, 0, 16'h4521},
      '{0, 8'h00, 0, 1, 0, 0, 16'h0076},
      '{0, 8'h00, 0, 1, 0, 0, 16'h0076},
      '{1, 8'hAA, 1, 0, 1, 0, 16'h0076},
      '{1, 8'h11, 0, 0, 1, 1, 16'h0076},
      '{1, 8'h22, 1, 0, 2, 0, 16'h0076},
      '{0, 8'h00, 0, 1, 1, 0, 16'h00AA},
      '{0, 8'h00, 0, 1, 0, 0, 16'h2211}
    };

    do_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].f, tbl[i].r, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_cnt", i), 32'(data_cnt), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d tbl_pack", i), 32'(pack_cnt), 32'(tbl[i].pack));
      chk($sformatf("vec%0d tbl_dout", i), 32'(data_out), 32'(tbl[i].dout));
    end
    chk("empty after table", 32'(empty), 32'(1));

    // Fill to full, drop one beat, drain in order.
    do_reset();
    for (int i = 0; i < 32; i++) step(1, 8'(i + 1), 0, 0, "fill");
    chk("fill full", 32'(full), 32'(1));
    chk("fill cnt", 32'(data_cnt), 32'(16));
    step(1, 8'hFF, 0, 0, "drop");
    chk("drop pack", 32'(pack_cnt), 32'(0));
    chk("drop cnt", 32'(data_cnt), 32'(16));
`ifdef UART_PACK_FIFO_ERR_EN
    chk("drop ovf", 32'(ovf), 32'(1));
`endif
    step(0, 8'h00, 1, 0, "flush at full");
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 0, 1, "drain");
      chk("drain word", 32'(data_out), 32'({8'(2*i + 2), 8'(2*i + 1)}));
    end
    chk("drain empty", 32'(empty), 32'(1));

    // Completing write and read in the same cycle.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 8'(8'h30 + i), 0, 0, "pre5");
    step(1, 8'h5A, 0, 0, "half");
    step(1, 8'hA5, 0, 1, "simul");
    chk("simul cnt", 32'(data_cnt), 32'(5));
    chk("simul dout", 32'(data_out), 32'(16'h3130));
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 1, "simul drain");
    chk("simul last", 32'(data_out), 32'(16'hA55A));

    // Read while empty, then reset in the middle of filling.
    step(0, 8'h00, 0, 1, "empty read");
    chk("empty read dout", 32'(data_out), 32'(16'hA55A));
`ifdef UART_PACK_FIFO_ERR_EN
    chk("empty read udf", 32'(udf), 32'(1));
`endif
    for (int i = 0; i < 15; i++) step(1, 8'(i), 0, 0, "midfill");
    chk("midfill cnt", 32'(data_cnt), 32'(7));
    chk("midfill pack", 32'(pack_cnt), 32'(1));
    do_reset();
    step(0, 8'h00, 0, 1, "post reset read");
    chk("post reset dout", 32'(data_out), 32'(0));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 4), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
